hdb3_t2d: RTL and testbench
===========================

// Module: hdb3_t2d
// PURPOSE
//  HDB3 receive-side decoder: converts a ternary polar symbol stream (+1/-1/0) back to NRZ binary.
//  Tracks the polarity of the last mark. A mark with the same polarity as the previous mark is a violation (V).
//  On a V, the V and its associated B (000V / B00V) are deleted from a 4-deep window.
//  Sits between the line receiver / slicer and the binary sink; also reports line-code errors.
// PARAMETERS
//  LAST_POL_INIT  1'b0  polarity assumed for the "previous mark" after reset (0 = -1, 1 = +1)
//  CNT_W          16    width of saturating error counter err_cnt
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      polar_in carries a symbol this cycle
//  polar_in   in   2      2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal
//  out_valid  out  1      data_out carries a decoded bit this cycle
//  data_out   out  1      decoded NRZ bit
//  v_det      out  1      pulse: accepted symbol was a violation
//  code_err   out  1      pulse: accepted symbol was 2'b11
//  zero_err   out  1      pulse: accepted zero made a run of >=4 zeros
//  v_err      out  1      pulse: V not preceded by two zeros (not 000V / B00V form)
//  err_cnt    out  CNT_W  saturating count of cycles with any error pulse
// BEHAVIOUR
//  Reset values
//  - On rst: all outputs 0, err_cnt = 0, sr[3:0] = 0, fill = 0, zrun = 0, last_pol = LAST_POL_INIT.
//  - rst mid-stream discards the window contents; nothing is flushed.
//  Accept rule
//  - A symbol is accepted on every posedge with in_valid=1. in_valid=0 means the cycle is idle:
//  - on an idle cycle all state holds and every pulse output is 0.
//  Classification of an accepted symbol
//  - mark:    10 or 01; pol = (10).
//  - zero:    00.
//  - illegal: 11. Treated as a zero for decoding; asserts code_err.
//  - V:       a mark with pol == last_pol. Asserts v_det.
//  - Every mark (V or not) sets last_pol <= pol.
//  Window sr[3:0] (sr[0] = newest)
//  - newbit = mark && !V.
//  - On a V: sr[2:0] are cleared before shifting (removes the B at sr[2]); newbit = 0.
//  - Shift: sr <= {V ? 3'b000 : sr[2:0], newbit}.
//  Output and latency
//  - On accept with fill==4: data_out <= sr[3] and out_valid <= 1.
//  - Otherwise out_valid <= 0 (data_out holds its value).
//  - fill saturates at 4, so the first 4 accepts after reset produce no output.
//  - Latency: a symbol accepted at edge k appears on data_out after the 4th following accept edge.
//  - With in_valid held at 1 this is 4 cycles.
//  Zero-run counter
//  - zrun counts consecutive zero/illegal symbols; it saturates at 7 and a mark resets it to 0.
//  - zero_err pulses on each accepted zero/illegal symbol that makes zrun >= 4.
//  V form check
//  - v_err pulses on a V when sr[0] | sr[1] is 1 (the two preceding symbols are not zeros).
//  - The deletion is still performed.
//  Pulses and error counter
//  - All pulse outputs are registered, one cycle after the accept edge, and high for 1 cycle.
//  - Several pulses may assert in the same cycle.
//  - err_cnt increments by exactly 1 in that cycle if any of code_err/zero_err/v_err asserts.
//  - err_cnt holds at 2^CNT_W-1.
//  Illegal first mark
//  - The first mark after reset equal to LAST_POL_INIT is decoded as V (v_err if not preceded by zeros).
// TESTING
//  1. Continuous stream +,-,+,-,0,0,0,0 then zeros (in_valid=1)
//     -> bits 1,1,1,1,0.. with out_valid from the 5th accept.
//     -> v_det=0. zero_err only on the 4th zero onward.
//  2. 10,00,00,00,10 (000V)
//     -> v_det on the 5th symbol; decoded 1,0,0,0,0; v_err=0.
//  3. 10,01,00,00,01 (B00V)
//     -> the B is deleted; decoded 1,0,0,0,0; v_det=1, v_err=0, err_cnt unchanged.
//  4. Symbol 11 inside a mark stream
//     -> code_err 1 cycle, decoded as 0, err_cnt +1.
//     -> 11 followed by 3 zeros also gives zero_err (err_cnt +1 that cycle, not +2).
//  5. 10,10 back-to-back
//     -> v_det and v_err on the 2nd symbol; the first 1 is cleared.
//  6. in_valid gaps and rst asserted mid-window, then CNT_W=2 with 5 errors
//     -> gaps: no state change and out_valid=0 on gap cycles.
//     -> rst: all outputs and state at reset values next cycle; 4 accepts needed before out_valid.
//     -> CNT_W=2: err_cnt saturates at 3.

Source files
------------

// File: rtl/hdb3_t2d_if.sv
// rtl/hdb3_t2d_if.sv - symbol-in / bit-out stream bundle for the HDB3 decoder
//
// Signals:
//   in_valid   polar_in carries a symbol this cycle
//   polar_in   2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal
//   out_valid  data_out carries a decoded bit this cycle
//   data_out   decoded NRZ bit
// Modports:
//   master     symbol source / bit sink (drives in_valid, polar_in)
//   slave      decoder (drives out_valid, data_out)
interface hdb3_t2d_if;
  logic       in_valid;
  logic [1:0] polar_in;
  logic       out_valid;
  logic       data_out;

  modport master (output in_valid, output polar_in, input out_valid, input data_out);
  modport slave  (input in_valid, input polar_in, output out_valid, output data_out);
endinterface

// File: rtl/hdb3_t2d.sv
// rtl/hdb3_t2d.sv - HDB3 ternary-to-NRZ decoder with line-code error reporting
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   lane       hdb3_t2d_if.slave: in_valid/polar_in in, out_valid/data_out out
//   v_det      pulse: accepted symbol was a violation
//   code_err   pulse: accepted symbol was 2'b11
//   zero_err   pulse: accepted zero made a run of >= 4 zeros
//   v_err      pulse: violation not preceded by two zeros
//   err_cnt    saturating count of cycles with any error pulse
module hdb3_t2d #(
  parameter logic LAST_POL_INIT = 1'b0,
  parameter int   CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  hdb3_t2d_if.slave        lane,
  output logic             v_det,
  output logic             code_err,
  output logic             zero_err,
  output logic             v_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [3:0] sr;        // decode window, sr[0] newest
  logic [2:0] fill;      // accepts since reset, saturating at 4
  logic [2:0] zrun;      // consecutive zero/illegal run, saturating at 7
  logic       last_pol;  // polarity of the most recent mark

  logic       is_mark;
  logic       pol;
  logic       is_v;
  logic       new_bit;
  logic [2:0] zrun_nxt;
  logic       c_err_nxt;
  logic       z_err_nxt;
  logic       v_err_nxt;
  logic       any_err;

  always_comb begin
    is_mark   = (lane.polar_in == 2'b10) || (lane.polar_in == 2'b01);
    pol       = (lane.polar_in == 2'b10);
    is_v      = is_mark && (pol == last_pol);
    new_bit   = is_mark && !is_v;
    // Illegal symbols decode as zeros, so they extend the zero run too.
    zrun_nxt  = is_mark ? 3'd0 : ((zrun == 3'd7) ? 3'd7 : zrun + 3'd1);
    c_err_nxt = (lane.polar_in == 2'b11);
    z_err_nxt = !is_mark && (zrun_nxt >= 3'd4);
    // A well-formed 000V / B00V has zeros in the two slots just before V.
    v_err_nxt = is_v && (sr[0] | sr[1]);
    any_err   = c_err_nxt | z_err_nxt | v_err_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr             <= 4'b0000;
      fill           <= 3'd0;
      zrun           <= 3'd0;
      last_pol       <= LAST_POL_INIT;
      lane.out_valid <= 1'b0;
      lane.data_out  <= 1'b0;
      v_det          <= 1'b0;
      code_err       <= 1'b0;
      zero_err       <= 1'b0;
      v_err          <= 1'b0;
      err_cnt        <= '0;
    end else begin
      lane.out_valid <= 1'b0;
      v_det          <= 1'b0;
      code_err       <= 1'b0;
      zero_err       <= 1'b0;
      v_err          <= 1'b0;
      if (lane.in_valid) begin
        // On V, the B (or the zero in its slot) sits at sr[2]; wipe the
        // three younger slots so both B and V leave as zeros.
        sr <= {is_v ? 3'b000 : sr[2:0], new_bit};
        if (fill == 3'd4) begin
          lane.out_valid <= 1'b1;
          lane.data_out  <= sr[3];
        end else begin
          fill <= fill + 3'd1;
        end
        if (is_mark) begin
          last_pol <= pol;
        end
        zrun     <= zrun_nxt;
        v_det    <= is_v;
        code_err <= c_err_nxt;
        zero_err <= z_err_nxt;
        v_err    <= v_err_nxt;
        if (any_err && (err_cnt != {CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdb3_t2d.sv
// tb/tb_hdb3_t2d.sv - scoreboard bench for hdb3_t2d (16-bit and 2-bit counters)
module tb_hdb3_t2d;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdb3_t2d_if if_a ();
  hdb3_t2d_if if_b ();

  logic        v_det_a, code_err_a, zero_err_a, v_err_a;
  logic [15:0] err_cnt_a;
  logic        v_det_b, code_err_b, zero_err_b, v_err_b;
  logic [1:0]  err_cnt_b;

  hdb3_t2d #(.LAST_POL_INIT(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .lane(if_a.slave),
    .v_det(v_det_a), .code_err(code_err_a), .zero_err(zero_err_a),
    .v_err(v_err_a), .err_cnt(err_cnt_a)
  );

  hdb3_t2d #(.LAST_POL_INIT(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .lane(if_b.slave),
    .v_det(v_det_b), .code_err(code_err_b), .zero_err(zero_err_b),
    .v_err(v_err_b), .err_cnt(err_cnt_b)
  );

  typedef struct {
    bit ov;
    bit d;
    bit vd;
    bit ce;
    bit ze;
    bit ve;
    int cnt_a;
    int cnt_b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the full history of decoded bits since reset, where a
  // violation rewrites the three most recent entries to zero.
  bit hist[$];
  bit prev_pol;
  int zrun_m;
  int cnt_a_m;
  int cnt_b_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hist_at(input int idx);
    if (idx < 0) return 1'b0;
    return hist[idx];
  endfunction

  task automatic model_reset();
    hist.delete();
    prev_pol = 1'b0;
    zrun_m   = 0;
    cnt_a_m  = 0;
    cnt_b_m  = 0;
  endtask

  task automatic model_accept(input logic [1:0] s);
    exp_t e;
    bit   mark;
    bit   p;
    bit   v;
    int   n;
    mark = (s == 2'b10) || (s == 2'b01);
    p    = (s == 2'b10);
    v    = mark && (p == prev_pol);
    n    = hist.size();
    e.ov = (n >= 4);
    e.d  = (n >= 4) ? hist[n-4] : 1'b0;
    e.ve = v && (hist_at(n-1) | hist_at(n-2));
    if (v) begin
      for (int k = 1; k <= 3; k++) begin
        if (n - k >= 0) hist[n-k] = 1'b0;
      end
    end
    hist.push_back(mark && !v);
    if (mark) begin
      prev_pol = p;
      zrun_m   = 0;
    end else begin
      zrun_m++;
    end
    e.vd = v;
    e.ce = (s == 2'b11);
    e.ze = !mark && (zrun_m >= 4);
    if (e.ce || e.ze || e.ve) begin
      if (cnt_a_m < 65535) cnt_a_m++;
      if (cnt_b_m < 3)     cnt_b_m++;
    end
    e.cnt_a = cnt_a_m;
    e.cnt_b = cnt_b_m;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] s);
    if_a.in_valid = v;
    if_a.polar_in = s;
    if_b.in_valid = v;
    if_b.polar_in = s;
    if (v) model_accept(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    if_a.in_valid = 1'b0;
    if_b.in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Symbols are packed MSB-first, two bits each.
  task automatic play(input logic [63:0] seq, input int len);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, seq[2*(len-1-i) +: 2]);
    end
  endtask

  // Monitor: pops one expectation per accepted cycle, checks idle cycles.
  int hold_a = 0;
  int hold_b = 0;

  initial begin
    logic acc;
    logic was_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      acc     = if_a.in_valid;
      was_rst = rst;
      @(negedge clk);
      if (was_rst) begin
        chk("rst_out_valid", {31'd0, if_a.out_valid}, 0);
        chk("rst_data_out",  {31'd0, if_a.data_out}, 0);
        chk("rst_pulses", {28'd0, v_det_a, code_err_a, zero_err_a, v_err_a}, 0);
        chk("rst_err_cnt_a", {16'd0, err_cnt_a}, 0);
        chk("rst_err_cnt_b", {30'd0, err_cnt_b}, 0);
        hold_a = 0;
        hold_b = 0;
      end else if (acc) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_valid", {31'd0, if_a.out_valid}, {31'd0, e.ov});
          if (e.ov) chk("data_out", {31'd0, if_a.data_out}, {31'd0, e.d});
          chk("v_det",    {31'd0, v_det_a},    {31'd0, e.vd});
          chk("code_err", {31'd0, code_err_a}, {31'd0, e.ce});
          chk("zero_err", {31'd0, zero_err_a}, {31'd0, e.ze});
          chk("v_err",    {31'd0, v_err_a},    {31'd0, e.ve});
          chk("err_cnt_a", {16'd0, err_cnt_a}, e.cnt_a);
          chk("err_cnt_b", {30'd0, err_cnt_b}, e.cnt_b);
          chk("b_out_valid", {31'd0, if_b.out_valid}, {31'd0, e.ov});
          if (e.ov) chk("b_data_out", {31'd0, if_b.data_out}, {31'd0, e.d});
          hold_a = e.cnt_a;
          hold_b = e.cnt_b;
        end
      end else begin
        chk("idle_out_valid", {31'd0, if_a.out_valid}, 0);
        chk("idle_pulses", {28'd0, v_det_a, code_err_a, zero_err_a, v_err_a}, 0);
        chk("idle_err_cnt_a", {16'd0, err_cnt_a}, hold_a);
        chk("idle_err_cnt_b", {30'd0, err_cnt_b}, hold_b);
      end
    end
  end

  initial begin
    int r;
    if_a.in_valid = 1'b0;
    if_a.polar_in = 2'b00;
    if_b.in_valid = 1'b0;
    if_b.polar_in = 2'b00;
    model_reset();
    #1;
    do_reset();

    // +,-,+,-, then zeros
    play(64'b10_01_10_01_00_00_00_00_00_00_00_00, 12);
    do_reset();
    // 000V, then flush
    play(64'b10_00_00_00_10_00_00_00_00, 9);
    do_reset();
    // B00V, then flush
    play(64'b10_01_00_00_01_00_00_00_00, 9);
    do_reset();
    // illegal inside marks, then illegal followed by three zeros
    play(64'b10_01_11_10_01_11_00_00_00_10_00_00_00_00, 14);
    do_reset();
    // back-to-back same polarity
    play(64'b10_10_00_00_00_00_00, 7);
    do_reset();
    // first mark equal to the initial polarity
    play(64'b01_00_00_00_00, 5);

    // gaps mid-window, then reset mid-window
    drive(1'b1, 2'b10);
    drive(1'b0, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b0, 2'b11);
    drive(1'b0, 2'b10);
    drive(1'b1, 2'b10);
    do_reset();
    play(64'b10_01_10_01_10_01, 6);

    // five errors: 2-bit counter must stop at 3
    do_reset();
    play(64'b11_11_11_11_11, 5);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    chk("sat_cnt_b", {30'd0, err_cnt_b}, 3);
    chk("sat_cnt_a", {16'd0, err_cnt_a}, 5);

    // randomized stream
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 10) begin
        drive(1'b0, 2'($urandom_range(0, 3)));
      end else if (r < 14) begin
        drive(1'b1, 2'b11);
      end else if (r < 50) begin
        drive(1'b1, 2'b00);
      end else if (r < 85) begin
        drive(1'b1, prev_pol ? 2'b01 : 2'b10);
      end else begin
        drive(1'b1, prev_pol ? 2'b10 : 2'b01);
      end
    end

    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
